// File: rtl/gpio_port_bank_if.sv
// Register-access bus between the SPI slave front end and the GPIO port bank.
// The interrupt line travels with it, back to the front end.
interface gpio_port_bank_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic             rd_en;
  logic [3:0]       addr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, irq);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, irq);
endinterface

// File: rtl/gpio_port_bank.sv
// GPIO port bank: per-pin direction/output/pull registers, synchronised and
// optionally debounced inputs, rise/fall capture into W1C status, and a registered irq.
module gpio_port_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_LEN     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  gpio_port_bank_if.slave  bus,
  input  logic [WIDTH-1:0] pad_y,
  output logic [WIDTH-1:0] pad_a,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] pad_pu,
  output logic [WIDTH-1:0] pad_pd
);
  localparam int CNT_W = $clog2(DEB_LEN);

  localparam logic [3:0] ADDR_OUT     = 4'h0;
  localparam logic [3:0] ADDR_OE      = 4'h1;
  localparam logic [3:0] ADDR_PU      = 4'h2;
  localparam logic [3:0] ADDR_PD      = 4'h3;
  localparam logic [3:0] ADDR_IN      = 4'h4;
  localparam logic [3:0] ADDR_RISE_EN = 4'h5;
  localparam logic [3:0] ADDR_FALL_EN = 4'h6;
  localparam logic [3:0] ADDR_STATUS  = 4'h7;
  localparam logic [3:0] ADDR_DEB_EN  = 4'h8;

  logic [WIDTH-1:0] out_r, oe_r, pu_r, pd_r;
  logic [WIDTH-1:0] rise_en_r, fall_en_r, deb_en_r, status_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] filt_r, filt_nxt;
  logic [CNT_W-1:0] cnt_r   [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] rise, fall, st_set, st_clr;
  logic [WIDTH-1:0] rd_mux;
  logic [WIDTH-1:0] rdata_r;
  logic             irq_r;

  // Pull-up wins a pull conflict; both pulls are released while the pin drives.
  assign pad_a  = out_r;
  assign pad_oe = oe_r;
  assign pad_pu = pu_r & ~oe_r;
  assign pad_pd = pd_r & ~pu_r & ~oe_r;

  assign bus.rdata = rdata_r;
  assign bus.irq   = irq_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r     <= '0;
      oe_r      <= '0;
      pu_r      <= '0;
      pd_r      <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
      deb_en_r  <= '0;
    end else if (bus.wr_en) begin
      case (bus.addr)
        ADDR_OUT:     out_r     <= bus.wdata;
        ADDR_OE:      oe_r      <= bus.wdata;
        ADDR_PU:      pu_r      <= bus.wdata;
        ADDR_PD:      pd_r      <= bus.wdata;
        ADDR_RISE_EN: rise_en_r <= bus.wdata;
        ADDR_FALL_EN: fall_en_r <= bus.wdata;
        ADDR_DEB_EN:  deb_en_r  <= bus.wdata;
        default:      ;
      endcase
    end
  end

  // Input synchroniser chain; stage 0 samples the asynchronous pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
    end else begin
      sync_r[0] <= pad_y;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
    end
  end

  assign sync_last = sync_r[SYNC_STAGES-1];

  // Debounce: filt takes the new level on the DEB_LEN-th consecutive differing sample.
  always_comb begin
    filt_nxt = filt_r;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (!deb_en_r[i]) begin
        filt_nxt[i] = sync_last[i];
      end else if (sync_last[i] != filt_r[i]) begin
        if (cnt_r[i] == CNT_W'(DEB_LEN - 1)) filt_nxt[i] = sync_last[i];
        else                                 cnt_nxt[i] = cnt_r[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_r <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_r[i] <= '0;
    end else begin
      filt_r <= filt_nxt;
      for (int i = 0; i < WIDTH; i++) cnt_r[i] <= cnt_nxt[i];
    end
  end

  assign rise   = ~filt_r & filt_nxt;
  assign fall   = filt_r & ~filt_nxt;
  assign st_set = (rise & rise_en_r) | (fall & fall_en_r);
  assign st_clr = (bus.wr_en && bus.addr == ADDR_STATUS) ? bus.wdata : '0;

  // A new edge overrides a simultaneous write-1-to-clear of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_r <= '0;
      irq_r    <= 1'b0;
    end else begin
      status_r <= (status_r & ~st_clr) | st_set;
      irq_r    <= |status_r;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_OUT:     rd_mux = out_r;
      ADDR_OE:      rd_mux = oe_r;
      ADDR_PU:      rd_mux = pu_r;
      ADDR_PD:      rd_mux = pd_r;
      ADDR_IN:      rd_mux = filt_r;
      ADDR_RISE_EN: rd_mux = rise_en_r;
      ADDR_FALL_EN: rd_mux = fall_en_r;
      ADDR_STATUS:  rd_mux = status_r;
      ADDR_DEB_EN:  rd_mux = deb_en_r;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata_r <= '0;
    else if (bus.rd_en)  rdata_r <= rd_mux;
  end
endmodule

// File: tb/tb_gpio_port_bank.sv
// Bench for gpio_port_bank: register-map model checked every cycle plus
// directed scenarios with literal expectations.
module tb_gpio_port_bank;
  localparam int W   = 8;
  localparam int SS  = 2;
  localparam int DL  = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] pad_y;
  logic [W-1:0] pad_a, pad_oe, pad_pu, pad_pd;

  gpio_port_bank_if #(.WIDTH(W)) bus ();

  gpio_port_bank #(.WIDTH(W), .SYNC_STAGES(SS), .DEB_LEN(DL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .pad_y  (pad_y),
    .pad_a  (pad_a),
    .pad_oe (pad_oe),
    .pad_pu (pad_pu),
    .pad_pd (pad_pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: register file indexed by address, delay line for the synchroniser,
  // and a run length of consecutive samples that disagree with IN.
  logic [W-1:0] m_reg  [16];
  logic [W-1:0] m_pipe [SS];
  logic [W-1:0] m_in, m_rdata, m_sy, m_nin, m_set, m_clr;
  logic         m_irq;
  int           m_run [W];

  function automatic logic [W-1:0] m_read(input logic [3:0] a);
    if (a == 4'h4)      return m_in;
    else if (a <= 4'h8) return m_reg[a];
    else                return '0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int a = 0; a < 16; a++) m_reg[a] = '0;
        for (int s = 0; s < SS; s++) m_pipe[s] = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_in = '0; m_rdata = '0; m_irq = 1'b0;
      end else begin
        m_sy = m_pipe[SS-1];
        for (int i = 0; i < W; i++) begin
          m_nin[i] = m_in[i];
          if (!m_reg[8][i]) begin
            m_nin[i] = m_sy[i];
            m_run[i] = 0;
          end else if (m_sy[i] != m_in[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= DL) begin
              m_nin[i] = m_sy[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        m_set = (~m_in & m_nin & m_reg[5]) | (m_in & ~m_nin & m_reg[6]);
        m_clr = (bus.wr_en && bus.addr == 4'h7) ? bus.wdata : '0;
        m_irq = |m_reg[7];
        if (bus.rd_en) m_rdata = m_read(bus.addr);
        m_reg[7] = (m_reg[7] & ~m_clr) | m_set;
        if (bus.wr_en && bus.addr <= 4'h8 && bus.addr != 4'h4 && bus.addr != 4'h7)
          m_reg[bus.addr] = bus.wdata;
        m_in = m_nin;
        for (int s = SS - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = pad_y;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("pad_a",  pad_a,  m_reg[0]);
      check("pad_oe", pad_oe, m_reg[1]);
      check("pad_pu", pad_pu, m_reg[2] & ~m_reg[1]);
      check("pad_pd", pad_pd, m_reg[3] & ~m_reg[2] & ~m_reg[1]);
      check("rdata",  bus.rdata, m_rdata);
      check("irq",    W'(bus.irq), W'(m_irq));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [W-1:0] exp, input string nm);
    bus.rd_en = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check(nm, bus.rdata, exp);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    pad_y = 8'hFF;
    rst_n = 1'b0;
    cyc(2);
    check("rst_pad_a",  pad_a,  8'h00);
    check("rst_pad_oe", pad_oe, 8'h00);
    check("rst_pad_pu", pad_pu, 8'h00);
    check("rst_rdata",  bus.rdata, 8'h00);
    check("rst_irq",    W'(bus.irq), 8'h00);
    rst_n = 1'b1;
    cyc(4);
    rd(4'h4, 8'hFF, "in_after_reset");
    rd(4'h7, 8'h00, "status_after_reset");
    check("irq_after_reset", W'(bus.irq), 8'h00);

    wr(4'h1, 8'h0F); wr(4'h0, 8'hA5); wr(4'h2, 8'hFF); wr(4'h3, 8'hFF);
    check("oe_lit", pad_oe, 8'h0F);
    check("a_lit",  pad_a,  8'hA5);
    check("pu_lit", pad_pu, 8'hF0);
    check("pd_lit", pad_pd, 8'h00);
    wr(4'h2, 8'h00);
    check("pd_lit2", pad_pd, 8'hF0);
    rd(4'h3, 8'hFF, "pd_reg_kept");

    // Rising edge on pin 0 with RISE_EN[0].
    pad_y = 8'hFE; cyc(4);
    wr(4'h5, 8'h01);
    pad_y = 8'hFF;
    cyc(3);
    check("irq_before", W'(bus.irq), 8'h00);
    cyc(1);
    check("irq_rise", W'(bus.irq), 8'h01);
    rd(4'h7, 8'h01, "status_rise");
    wr(4'h7, 8'h01);
    cyc(1);
    check("irq_cleared", W'(bus.irq), 8'h00);
    rd(4'h7, 8'h00, "status_cleared");

    // Debounced fall on pin 1: short glitch rejected, full-length pulse accepted.
    wr(4'h6, 8'h02); wr(4'h8, 8'h02);
    pad_y = 8'hFD; cyc(DL - 1); pad_y = 8'hFF;
    cyc(20);
    rd(4'h4, 8'hFF, "glitch_in");
    rd(4'h7, 8'h00, "glitch_status");
    pad_y = 8'hFD; cyc(DL); pad_y = 8'hFF;
    cyc(2);
    rd(4'h4, 8'hFD, "deb_in");
    rd(4'h7, 8'h02, "deb_status");
    cyc(20);
    rd(4'h4, 8'hFF, "deb_recover");
    wr(4'h7, 8'h02);
    cyc(2);

    // Rise on pin 0 lands on the same edge as its W1C.
    pad_y = 8'hFE; cyc(4);
    pad_y = 8'hFF;
    cyc(2);
    wr(4'h7, 8'h01);
    rd(4'h7, 8'h01, "set_wins");
    wr(4'h7, 8'h01);
    cyc(2);

    rd(4'h0, 8'hA5, "read_out");
    rd(4'hC, 8'h00, "read_unmapped");
    wr(4'h4, 8'h55);
    rd(4'h4, 8'hFF, "in_readonly");

    // Read and write STATUS together: old value returned.
    pad_y = 8'hFE; cyc(4); pad_y = 8'hFF; cyc(4);
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = 4'h7; bus.wdata = 8'h01;
    @(negedge clk);
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    check("rd_wr_same", bus.rdata, 8'h01);
    rd(4'h7, 8'h00, "rd_wr_cleared");

    // Reset in the middle of a debounce count.
    rd(4'h0, 8'hA5, "pre_reset_read");
    pad_y = 8'hFD; cyc(5);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_a",     pad_a,  8'h00);
    check("mid_rst_oe",    pad_oe, 8'h00);
    check("mid_rst_rdata", bus.rdata, 8'h00);
    check("mid_rst_irq",   W'(bus.irq), 8'h00);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    rd(4'h4, 8'hFD, "in_after_rst2");
    rd(4'h7, 8'h00, "status_after_rst2");
    rd(4'h8, 8'h00, "deb_en_after_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
